alarm_set: RTL and testbench
============================

ALARM_SET -- requirements
Module: alarm_set

Interface
REQ-001 The block SHALL have parameter RESET_HOUR, default 6, the alarm hour loaded at reset (0-23).
REQ-002 The block SHALL have parameter RESET_MIN, default 0, the alarm minute loaded at reset (0-59).
REQ-003 The block SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, the synchronous, active-high reset.
REQ-005 The block SHALL have port btn_mode, input, 1, a level already synchronised to clk that advances the edit mode.
REQ-006 The block SHALL have port btn_up, input, 1, a level already synchronised to clk that increments the field under edit.
REQ-007 The block SHALL have port btn_down, input, 1, a level already synchronised to clk that decrements the field under edit.
REQ-008 The block SHALL have port alarm_time, output, 12, the committed alarm word consumed by the 12-bit equality comparator: [11:6] = hour in binary, [5:0] = minute in binary.
REQ-009 The block SHALL have port edit_word, output, 12, the shadow word under edit, in the same format as alarm_time, for display.
REQ-010 The block SHALL have port mode, output, 2, the edit state: 00 IDLE, 01 SET_HOUR, 10 SET_MIN.
REQ-011 The block SHALL have port alarm_wr, output, 1, a one-cycle pulse asserted in the same cycle that alarm_time takes a new value.

Function
REQ-012 The block SHALL detect button presses on rising edges only (previous-cycle level low, current level high), registering the previous level internally; a held button SHALL count as one press.
REQ-013 The state machine SHALL have states IDLE, SET_HOUR and SET_MIN, and a btn_mode press SHALL move IDLE->SET_HOUR, SET_HOUR->SET_MIN and SET_MIN->IDLE.
REQ-014 On the IDLE->SET_HOUR transition, the shadow word SHALL be loaded from alarm_time.
REQ-015 On the SET_MIN->IDLE transition, alarm_time SHALL be loaded from the shadow word on the next clock edge, with alarm_wr high for exactly that cycle (commit latency 1 cycle after the press edge is sampled).
REQ-016 alarm_time SHALL change only at commit or reset, so the comparator never sees a half-edited value.
REQ-017 In SET_HOUR, an up press SHALL increment the hour modulo 24 (23->0) and a down press SHALL decrement it modulo 24 (0->23).
REQ-018 In SET_MIN, an up press SHALL increment the minute modulo 60 (59->0) and a down press SHALL decrement it modulo 60 (0->59).
REQ-019 Editing the minute SHALL NOT carry into or borrow from the hour, and editing the hour SHALL NOT affect the minute.
REQ-020 In IDLE, up and down presses SHALL be ignored.
REQ-021 Rising edges of up and down in the same cycle SHALL be ignored (no change).
REQ-022 A mode press coinciding with an up or down press SHALL take priority; the up or down press SHALL be discarded.
REQ-023 Hour field values 24-63 and minute field values 60-63 SHALL be unreachable; every update SHALL keep the fields in range.
REQ-024 edit_word SHALL equal alarm_time whenever mode is IDLE.

Reset
REQ-025 When rst is high at a clock edge, the block SHALL set mode=IDLE, alarm_time={RESET_HOUR,RESET_MIN}, edit_word=alarm_time, alarm_wr=0, and clear the previous-level registers to 0.
REQ-026 A reset during SET_HOUR or SET_MIN SHALL discard the shadow edits with no alarm_wr pulse.
REQ-027 A button held high through reset release SHALL NOT register a press until it is released and pressed again; the previous-level registers SHALL capture the live level on the first cycle after reset.

Verification
REQ-028 Reset -> alarm_time=0x180 (6:00), mode=00, alarm_wr=0.
REQ-029 From reset: mode, up x3, mode, up x30, mode -> alarm_time=0x25E (9:30), a single alarm_wr pulse, alarm_time unchanged until that cycle.
REQ-030 Wrap: with the hour at 23, up -> hour 0; with the minute at 0, down -> minute 59; the other field is unchanged.
REQ-031 Simultaneous up and down edge in SET_MIN -> edit_word unchanged; mode+up in the same cycle in SET_HOUR -> mode=10, hour unchanged.
REQ-032 rst asserted in SET_MIN after edits -> alarm_time keeps its pre-edit value, mode=00, no alarm_wr.
REQ-033 btn_up held high for 20 cycles in SET_HOUR -> hour +1 only; buttons pressed in IDLE -> no change.

Source files
------------

// File: rtl/alarm_set.sv
// Alarm time setter: edits a shadow hour/minute word with up/down buttons and
// commits it to the comparator word only when the edit sequence completes.
module alarm_set #(
  parameter int unsigned RESET_HOUR = 6,
  parameter int unsigned RESET_MIN  = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_mode,
  input  logic        btn_up,
  input  logic        btn_down,
  output logic [11:0] alarm_time,
  output logic [11:0] edit_word,
  output logic [1:0]  mode,
  output logic        alarm_wr
);

  localparam int unsigned FIELD_W  = 6;
  localparam int unsigned HOUR_MAX = 23;
  localparam int unsigned MIN_MAX  = 59;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    SET_HOUR = 2'b01,
    SET_MIN  = 2'b10
  } state_e;

  state_e               state_q, state_d;
  logic [FIELD_W-1:0]   alarm_hour_q, alarm_hour_d;
  logic [FIELD_W-1:0]   alarm_min_q, alarm_min_d;
  logic [FIELD_W-1:0]   edit_hour_q, edit_hour_d;
  logic [FIELD_W-1:0]   edit_min_q, edit_min_d;
  logic                 alarm_wr_q, alarm_wr_d;
  logic [2:0]           prev_q, prev_d;
  logic                 armed_q, armed_d;

  logic                 mode_edge_c;
  logic                 up_edge_c;
  logic                 down_edge_c;
  logic                 adjust_c;

  function automatic logic [FIELD_W-1:0] wrap_inc(input logic [FIELD_W-1:0] v,
                                                  input logic [FIELD_W-1:0] max);
    return (v == max) ? '0 : v + FIELD_W'(1);
  endfunction

  function automatic logic [FIELD_W-1:0] wrap_dec(input logic [FIELD_W-1:0] v,
                                                  input logic [FIELD_W-1:0] max);
    return (v == '0) ? max : v - FIELD_W'(1);
  endfunction

  // Edges are masked for the first cycle after reset so a held button is not a press.
  assign mode_edge_c = armed_q & btn_mode & ~prev_q[2];
  assign up_edge_c   = armed_q & btn_up   & ~prev_q[1];
  assign down_edge_c = armed_q & btn_down & ~prev_q[0];
  assign adjust_c    = up_edge_c ^ down_edge_c;

  always_comb begin
    state_d      = state_q;
    alarm_hour_d = alarm_hour_q;
    alarm_min_d  = alarm_min_q;
    edit_hour_d  = edit_hour_q;
    edit_min_d   = edit_min_q;
    alarm_wr_d   = 1'b0;
    prev_d       = {btn_mode, btn_up, btn_down};
    armed_d      = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (mode_edge_c) begin
          state_d     = SET_HOUR;
          edit_hour_d = alarm_hour_q;
          edit_min_d  = alarm_min_q;
        end
      end
      SET_HOUR: begin
        if (mode_edge_c) begin
          state_d = SET_MIN;
        end else if (adjust_c) begin
          edit_hour_d = up_edge_c ? wrap_inc(edit_hour_q, FIELD_W'(HOUR_MAX))
                                  : wrap_dec(edit_hour_q, FIELD_W'(HOUR_MAX));
        end
      end
      SET_MIN: begin
        if (mode_edge_c) begin
          state_d      = IDLE;
          alarm_hour_d = edit_hour_q;
          alarm_min_d  = edit_min_q;
          alarm_wr_d   = 1'b1;
        end else if (adjust_c) begin
          edit_min_d = up_edge_c ? wrap_inc(edit_min_q, FIELD_W'(MIN_MAX))
                                 : wrap_dec(edit_min_q, FIELD_W'(MIN_MAX));
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Shadow word is reloaded at reset so it mirrors alarm_time while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      alarm_hour_q <= FIELD_W'(RESET_HOUR);
      alarm_min_q  <= FIELD_W'(RESET_MIN);
      edit_hour_q  <= FIELD_W'(RESET_HOUR);
      edit_min_q   <= FIELD_W'(RESET_MIN);
      alarm_wr_q   <= 1'b0;
      prev_q       <= '0;
      armed_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      alarm_hour_q <= alarm_hour_d;
      alarm_min_q  <= alarm_min_d;
      edit_hour_q  <= edit_hour_d;
      edit_min_q   <= edit_min_d;
      alarm_wr_q   <= alarm_wr_d;
      prev_q       <= prev_d;
      armed_q      <= armed_d;
    end
  end

  assign alarm_time = {alarm_hour_q, alarm_min_q};
  assign edit_word  = {edit_hour_q, edit_min_q};
  assign mode       = state_q;
  assign alarm_wr   = alarm_wr_q;

endmodule

// File: tb/tb_alarm_set.sv
// Bench for alarm_set: directed scenarios plus random button traffic, checked
// every cycle against a behavioural hour/minute model.
module tb_alarm_set;

  logic        clk = 1'b0;
  logic        rst;
  logic        btn_mode, btn_up, btn_down;
  logic [11:0] alarm_time, edit_word;
  logic [1:0]  mode;
  logic        alarm_wr;

  int tests = 0;
  int fails = 0;
  int wr_cnt = 0;

  // Behavioural model: times as plain integers, mode as 0/1/2.
  int m_mode, m_ah, m_am, m_eh, m_em;
  bit m_wr, m_valid, m_armed;
  bit p_mode, p_up, p_down;

  alarm_set #(.RESET_HOUR(6), .RESET_MIN(0)) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_mode   (btn_mode),
    .btn_up     (btn_up),
    .btn_down   (btn_down),
    .alarm_time (alarm_time),
    .edit_word  (edit_word),
    .mode       (mode),
    .alarm_wr   (alarm_wr)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] word(input int h, input int m);
    return {6'(h), 6'(m)};
  endfunction

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update from the levels present at the clock edge.
  always @(posedge clk) begin
    bit em, eu, ed;
    if (rst) begin
      m_valid = 1; m_mode = 0; m_ah = 6; m_am = 0; m_eh = 6; m_em = 0;
      m_wr = 0; m_armed = 0; p_mode = 0; p_up = 0; p_down = 0;
    end else if (m_valid) begin
      em = m_armed && btn_mode && !p_mode;
      eu = m_armed && btn_up   && !p_up;
      ed = m_armed && btn_down && !p_down;
      m_wr = 0;
      if (em) begin
        if (m_mode == 0) begin m_eh = m_ah; m_em = m_am; m_mode = 1; end
        else if (m_mode == 1) m_mode = 2;
        else begin m_ah = m_eh; m_am = m_em; m_wr = 1; m_mode = 0; end
      end else if (eu != ed && m_mode != 0) begin
        if (m_mode == 1) m_eh = eu ? (m_eh + 1) % 24 : (m_eh + 23) % 24;
        else             m_em = eu ? (m_em + 1) % 60 : (m_em + 59) % 60;
      end
      p_mode = btn_mode; p_up = btn_up; p_down = btn_down; m_armed = 1;
    end
  end

  // Per-cycle comparison just after each edge.
  always @(posedge clk) begin
    #1;
    if (m_valid) begin
      chk("alarm_time", alarm_time, word(m_ah, m_am));
      chk("edit_word", edit_word, word(m_eh, m_em));
      chk("mode", 12'(mode), 12'(m_mode));
      chk("alarm_wr", 12'(alarm_wr), 12'(m_wr));
      if (alarm_wr === 1'b1) wr_cnt++;
    end
  end

  task automatic drive(input bit m, input bit u, input bit d);
    @(negedge clk);
    btn_mode = m; btn_up = u; btn_down = d;
  endtask

  task automatic press(input bit m, input bit u, input bit d);
    drive(m, u, d);
    drive(0, 0, 0);
  endtask

  task automatic press_n(input bit u, input int n);
    for (int i = 0; i < n; i++) press(0, u, !u);
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1;
    @(negedge clk); rst = 0;
  endtask

  task automatic pin(input string name, input logic [11:0] act, input logic [11:0] model, input logic [11:0] lit);
    @(negedge clk);
    chk(name, act, lit);
    chk({name, "_model"}, model, lit);
  endtask

  initial begin
    int w0;
    rst = 1; btn_mode = 0; btn_up = 0; btn_down = 0;
    repeat (2) @(negedge clk);
    rst = 0;
    pin("reset_alarm", alarm_time, word(m_ah, m_am), 12'h180);
    chk("reset_mode", 12'(mode), 12'h000);
    chk("reset_wr", 12'(alarm_wr), 12'h000);

    // 6:00 -> 9:30 with a single commit pulse
    w0 = wr_cnt;
    press(1, 0, 0); press_n(1, 3); press(1, 0, 0); press_n(1, 30); press(1, 0, 0);
    pin("commit_930", alarm_time, word(m_ah, m_am), 12'h25E);
    chk("commit_pulses", 12'(wr_cnt - w0), 12'd1);

    // Hour and minute wrap, other field untouched
    press(1, 0, 0); press_n(0, 10);
    pin("hour_23", edit_word, word(m_eh, m_em), 12'h5DE);
    press_n(1, 1);
    pin("hour_wrap_up", edit_word, word(m_eh, m_em), 12'h01E);
    press(1, 0, 0); press_n(0, 30);
    pin("min_zero", edit_word, word(m_eh, m_em), 12'h000);
    press_n(0, 1);
    pin("min_wrap_down", edit_word, word(m_eh, m_em), 12'h03B);
    press(1, 0, 0);
    pin("commit_wrap", alarm_time, word(m_ah, m_am), 12'h03B);

    // Simultaneous up+down ignored; mode beats up
    press(1, 0, 0); press(1, 0, 0); press(0, 1, 1);
    pin("updown_same", edit_word, word(m_eh, m_em), 12'h03B);
    press(1, 0, 0); press(1, 0, 0); press(1, 1, 0);
    pin("mode_prio_mode", 12'(mode), 12'(m_mode), 12'h002);
    pin("mode_prio_word", edit_word, word(m_eh, m_em), 12'h03B);
    press(1, 0, 0);

    // Reset mid-edit discards shadow and emits no pulse
    do_reset();
    w0 = wr_cnt;
    press(1, 0, 0); press_n(1, 1); press(1, 0, 0); press_n(1, 5);
    do_reset();
    pin("rst_discard", alarm_time, word(m_ah, m_am), 12'h180);
    chk("rst_mode", 12'(mode), 12'h000);
    chk("rst_no_wr", 12'(wr_cnt - w0), 12'd0);

    // Held button counts once; idle presses ignored
    press(1, 0, 0);
    drive(0, 1, 0); repeat (19) @(negedge clk); drive(0, 0, 0);
    pin("held_up", edit_word, word(m_eh, m_em), 12'h1C0);
    press(1, 0, 0); press(1, 0, 0);
    press_n(1, 3); press_n(0, 2);
    pin("idle_ignore", alarm_time, word(m_ah, m_am), 12'h1C0);

    // Mode held through reset release is not a press
    btn_mode = 1;
    do_reset();
    repeat (3) @(negedge clk);
    pin("held_thru_rst", 12'(mode), 12'(m_mode), 12'h000);
    drive(0, 0, 0); press(1, 0, 0);
    pin("press_after_release", 12'(mode), 12'(m_mode), 12'h001);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst      = ($urandom_range(299) == 0);
      btn_mode = ($urandom_range(7) == 0);
      btn_up   = ($urandom_range(2) == 0);
      btn_down = ($urandom_range(2) == 0);
    end
    @(negedge clk);
    rst = 0; btn_mode = 0; btn_up = 0; btn_down = 0;
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
